// File: rtl/switch_debounce_pulse_pkg.sv
// Shared types and helpers for the switch conditioning block (switch_debounce_pulse).
package mcpnr_switch_pkg;

  typedef enum logic [1:0] {LO, CHK_HI, HI, CHK_LO} sw_state_t;

  // Width needed to hold a count from 0 up to n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return unsigned'($clog2(n + 1));
  endfunction

endpackage

// File: rtl/switch_debounce_pulse_if.sv
// Switch bundle: raw inputs from MCPNR_SWITCHES and the conditioned level/pulse outputs.
interface switch_debounce_pulse_if #(
  parameter int unsigned NSWITCH = 1
);
  import mcpnr_switch_pkg::*;

  logic [NSWITCH-1:0] I;
  logic [NSWITCH-1:0] LEVEL;
  logic [NSWITCH-1:0] RISE;
  logic [NSWITCH-1:0] FALL;

  modport master (output I, input LEVEL, input RISE, input FALL);
  modport slave  (input I, output LEVEL, output RISE, output FALL);

endinterface

// File: rtl/switch_debounce_pulse_chan.sv
// One switch channel: synchroniser, debounce FSM, registered level and edge pulses.
// Optional auto-repeat of RISE while held high: SWITCH_PULSE_REPEAT_EN.
module switch_debounce_chan
  import mcpnr_switch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  localparam int unsigned   CW         = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  sw_state_t              state, state_n;
  logic [CW-1:0]          cnt, cnt_n, cnt_cand;
  logic                   level_n, rise_n, fall_n;

`ifdef SWITCH_PULSE_REPEAT_EN
  localparam int unsigned   RW        = unsigned'($clog2(REPEAT_CYCLES));
  localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt, rcnt_n;
`endif

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], I};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= LO;
      cnt   <= '0;
      LEVEL <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      LEVEL <= level_n;
      RISE  <= rise_n;
      FALL  <= fall_n;
    end
  end

`ifdef SWITCH_PULSE_REPEAT_EN
  always_ff @(posedge CLK) begin
    if (RST) rcnt <= '0;
    else     rcnt <= rcnt_n;
  end
`endif

  // cnt_cand is the number of consecutive samples (including this one) that disagree with LEVEL.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    level_n  = LEVEL;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
`ifdef SWITCH_PULSE_REPEAT_EN
    rcnt_n   = rcnt;
`endif
    cnt_cand = ((state == LO) || (state == HI)) ? CW'(1) : cnt + CW'(1);

    case (state)
      LO, CHK_HI: begin
        if (s) begin
          if (cnt_cand == CNT_ACCEPT) begin
            state_n = HI;
            cnt_n   = '0;
            level_n = 1'b1;
            rise_n  = 1'b1;
`ifdef SWITCH_PULSE_REPEAT_EN
            rcnt_n  = '0;
`endif
          end else begin
            state_n = CHK_HI;
            cnt_n   = cnt_cand;
          end
        end else begin
          state_n = LO;
          cnt_n   = '0;
        end
      end
      HI, CHK_LO: begin
        if (!s) begin
          if (cnt_cand == CNT_ACCEPT) begin
            state_n = LO;
            cnt_n   = '0;
            level_n = 1'b0;
            fall_n  = 1'b1;
          end else begin
            state_n = CHK_LO;
            cnt_n   = cnt_cand;
          end
        end else begin
          state_n = HI;
          cnt_n   = '0;
`ifdef SWITCH_PULSE_REPEAT_EN
          // Repeat counter is frozen in CHK_LO and restarts on a rejected low glitch.
          if (state == CHK_LO) begin
            rcnt_n = '0;
          end else if (rcnt == RCNT_LAST) begin
            rise_n = 1'b1;
            rcnt_n = '0;
          end else begin
            rcnt_n = rcnt + RW'(1);
          end
`endif
        end
      end
      default: begin
        state_n = LO;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/switch_debounce_pulse.sv
// Multi-channel switch conditioner: NSWITCH independent debounce channels.
// Optional RISE auto-repeat while held: SWITCH_PULSE_REPEAT_EN.
module switch_debounce_pulse
  import mcpnr_switch_pkg::*;
#(
  parameter int unsigned NSWITCH         = 1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input logic                   CLK,
  input logic                   RST,
  switch_debounce_pulse_if.slave sw
);

  if (NSWITCH < 1) begin : g_bad_nswitch
    $error("NSWITCH must be >= 1");
  end

  for (genvar g = 0; g < NSWITCH; g++) begin : g_chan
    switch_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .CLK  (CLK),
      .RST  (RST),
      .I    (sw.I[g]),
      .LEVEL(sw.LEVEL[g]),
      .RISE (sw.RISE[g]),
      .FALL (sw.FALL[g])
    );
  end

endmodule

// File: tb/tb_switch_debounce_pulse.sv
// Self-checking bench for switch_debounce_pulse (3 channels, default timing).
module tb_switch_debounce_pulse;

  localparam int unsigned NS = 3;
  localparam int unsigned SS = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned RP = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  switch_debounce_pulse_if #(.NSWITCH(NS)) sw ();

  switch_debounce_pulse #(
    .NSWITCH(NS), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .sw (sw)
  );

  int checks = 0;
  int errors = 0;

  // Reference: level flips after DB consecutive synchronised samples that disagree with it.
  int m_pipe [NS][SS];
  bit m_level[NS];
  int m_run  [NS];
  int m_age  [NS];
  bit m_rise [NS];
  bit m_fall [NS];

  task automatic model_step(input bit r, input logic [NS-1:0] iv);
    for (int c = 0; c < NS; c++) begin
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (r) begin
        for (int k = 0; k < SS; k++) m_pipe[c][k] = 0;
        m_level[c] = 1'b0;
        m_run[c]   = 0;
        m_age[c]   = 0;
      end else begin
        bit s;
        s = (m_pipe[c][SS-1] != 0);
        for (int k = SS - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
        m_pipe[c][0] = iv[c] ? 1 : 0;
        if (s != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_level[c] = s;
            m_run[c]   = 0;
            m_age[c]   = 0;
            if (s) m_rise[c] = 1'b1;
            else   m_fall[c] = 1'b1;
          end
        end else if (m_run[c] > 0) begin
          m_run[c] = 0;
          m_age[c] = 0;
        end
`ifdef SWITCH_PULSE_REPEAT_EN
        else if (m_level[c]) begin
          if (m_age[c] == RP - 1) begin
            m_rise[c] = 1'b1;
            m_age[c]  = 0;
          end else begin
            m_age[c]++;
          end
        end
`endif
      end
    end
  endtask

  function automatic logic [NS-1:0] pack(input bit v[NS]);
    logic [NS-1:0] p;
    for (int c = 0; c < NS; c++) p[c] = v[c];
    return p;
  endfunction

  task automatic check_vec(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on negedge, advance one posedge, sample 1 time unit later.
  task automatic step(input bit r, input logic [NS-1:0] iv);
    @(negedge CLK);
    RST  = r;
    sw.I = iv;
    @(posedge CLK);
    model_step(r, iv);
    #1;
  endtask

  task automatic check_model(input string tag);
    check_vec({tag, "_level"}, sw.LEVEL, pack(m_level));
    check_vec({tag, "_rise"},  sw.RISE,  pack(m_rise));
    check_vec({tag, "_fall"},  sw.FALL,  pack(m_fall));
  endtask

  typedef struct {
    bit            rst;
    logic [NS-1:0] i;
    logic [NS-1:0] lvl;
    logic [NS-1:0] rise;
    logic [NS-1:0] fall;
  } vec_t;

  vec_t tbl[$];

  initial begin
    RST  = 1'b1;
    sw.I = '0;

    // Channel 0 only: reset with input high, 10-cycle high, 3-cycle glitch, 4-cycle pulse.
    for (int k = 0; k < 39; k++) begin
      vec_t v;
      v.rst  = (k < 3);
      v.i    = NS'((k < 10) || (k >= 17 && k < 20) || (k >= 28 && k < 32));
      v.lvl  = NS'((k >= 8 && k < 15) || (k >= 33 && k < 37));
      v.rise = NS'(k == 8 || k == 33);
      v.fall = NS'(k == 15 || k == 37);
      tbl.push_back(v);
    end

    foreach (tbl[n]) begin
      step(tbl[n].rst, tbl[n].i);
      check_vec($sformatf("tbl%0d_level", n), sw.LEVEL, tbl[n].lvl);
      check_vec($sformatf("tbl%0d_rise", n),  sw.RISE,  tbl[n].rise);
      check_vec($sformatf("tbl%0d_fall", n),  sw.FALL,  tbl[n].fall);
    end

    // Channel 0 rises while channel 2 falls on the same cycle.
    for (int k = 0; k < 8; k++) step(1'b0, 3'b100);
    check_vec("pre_multi_level", sw.LEVEL, 3'b100);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 3'b001);
      check_vec($sformatf("multi%0d_rise", k),  sw.RISE,  (k == 5) ? 3'b001 : 3'b000);
      check_vec($sformatf("multi%0d_fall", k),  sw.FALL,  (k == 5) ? 3'b100 : 3'b000);
      check_vec($sformatf("multi%0d_level", k), sw.LEVEL, (k >= 5) ? 3'b001 : 3'b100);
    end

    // Reset while CHK_HI holds CNT=3 aborts; full latency after release.
    step(1'b1, 3'b000);
    check_vec("rst_level", sw.LEVEL, 3'b000);
    step(1'b0, 3'b000);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 3'b001);
      check_vec($sformatf("abort_pre%0d_rise", k), sw.RISE, 3'b000);
    end
    step(1'b1, 3'b001);
    check_vec("abort_rst_rise",  sw.RISE,  3'b000);
    check_vec("abort_rst_level", sw.LEVEL, 3'b000);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 3'b001);
      check_vec($sformatf("abort_post%0d_rise", k),  sw.RISE,  (k == 5) ? 3'b001 : 3'b000);
      check_vec($sformatf("abort_post%0d_level", k), sw.LEVEL, (k == 5) ? 3'b001 : 3'b000);
    end

    // Long hold after acceptance, then release: count repeats and falls.
    begin
      int rises[$];
      int nfall = 0;
      int nrise_rel = 0;
      for (int k = 1; k <= 40; k++) begin
        step(1'b0, 3'b001);
        if (sw.RISE[0]) rises.push_back(k);
      end
`ifdef SWITCH_PULSE_REPEAT_EN
      check_int("repeat_count", rises.size(), 2);
      check_int("repeat_first", (rises.size() > 0) ? rises[0] : -1, 16);
      check_int("repeat_second", (rises.size() > 1) ? rises[1] : -1, 32);
`else
      check_int("hold_no_repeat", rises.size(), 0);
`endif
      for (int k = 0; k < 10; k++) begin
        step(1'b0, 3'b000);
        if (sw.FALL[0]) nfall++;
        if (sw.RISE[0]) nrise_rel++;
        if (k == 5) check_vec("release_fall", sw.FALL, 3'b001);
      end
      check_int("release_fall_count", nfall, 1);
      check_int("release_rise_count", nrise_rel, 0);
    end

    // Randomised traffic against the reference model.
    begin
      logic [NS-1:0] cur = '0;
      for (int n = 0; n < 1500; n++) begin
        logic [NS-1:0] tm;
        bit r;
        for (int c = 0; c < NS; c++) tm[c] = ($urandom_range(0, 5) == 0);
        r   = ($urandom_range(0, 149) == 0);
        cur = cur ^ tm;
        step(r, cur);
        check_model($sformatf("rnd%0d", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
